// File: rtl/spi_cfg_writer.sv
`default_nettype none
// =============================================================================
// Module  : spi_cfg_writer
// Purpose : Queues register-write commands and serializes each as one 16-bit
//           SPI write frame (nCS/SCLK/COPI) for the configuration peripheral.
// Rev     : 1.0
// =============================================================================
module spi_cfg_writer #(
    parameter int CLK_DIV    = 4,
    parameter int GAP        = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [3:0]                    cmd_addr,
    input  logic [7:0]                    cmd_data,
    output logic                          SCLK,
    output logic                          COPI,
    output logic                          nCS,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int PMAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int PW   = $clog2(PMAX);

    localparam logic [PW-1:0] c_DIV_RELOAD = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] c_GAP_RELOAD = PW'(GAP - 1);
    localparam logic [CW-1:0] c_FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [3:0]    c_MAX_ADDR   = 4'd4;
    localparam logic [4:0]    c_BITS       = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t         state_q;
    logic [PW-1:0]  phase_q;
    logic [4:0]     bit_cnt_q;
    logic [4:0]     bit_cnt_d;
    logic [14:0]    shift_q;
    logic           sclk_q;
    logic           copi_q;
    logic           ncs_q;
    logic           done_q;
    logic           err_q;

    logic [11:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;

    logic           w_accept;
    logic           w_bad_addr;
    logic           w_push;
    logic           w_pop;
    logic [15:0]    w_frame;

    // ---------------------------------------------------------------- FIFO
    assign cmd_ready  = (count_q != c_FULL_COUNT);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_bad_addr = (cmd_addr > c_MAX_ADDR);
    assign w_push     = w_accept && !w_bad_addr;
    assign w_pop      = (state_q == ST_IDLE) && (count_q != '0);
    assign w_frame    = {1'b1, 3'b000, mem_q[rd_ptr_q]};

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {cmd_addr, cmd_data};
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            err_q   <= w_accept && w_bad_addr;
        end
    end

    // ---------------------------------------------------------------- Serializer
    assign bit_cnt_d = (bit_cnt_q == c_BITS) ? bit_cnt_q : bit_cnt_q + 5'd1;

    // frame[15] goes straight to COPI at SETUP entry, so only 15 bits are kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            ncs_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_pop) begin
                        shift_q   <= w_frame[14:0];
                        copi_q    <= w_frame[15];
                        ncs_q     <= 1'b0;
                        sclk_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        phase_q   <= c_DIV_RELOAD;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (phase_q == '0) begin
                        sclk_q  <= 1'b1;
                        phase_q <= c_DIV_RELOAD;
                        state_q <= ST_HIGH;
                    end else begin
                        phase_q <= phase_q - PW'(1);
                    end
                end
                ST_HIGH: begin
                    if (phase_q == '0) begin
                        sclk_q    <= 1'b0;
                        bit_cnt_q <= bit_cnt_d;
                        shift_q   <= {shift_q[13:0], 1'b0};
                        if (bit_cnt_d != c_BITS) begin
                            copi_q <= shift_q[14];
                        end
                        phase_q <= c_DIV_RELOAD;
                        state_q <= ST_LOW;
                    end else begin
                        phase_q <= phase_q - PW'(1);
                    end
                end
                ST_LOW: begin
                    if (phase_q == '0) begin
                        if (bit_cnt_q < c_BITS) begin
                            sclk_q  <= 1'b1;
                            phase_q <= c_DIV_RELOAD;
                            state_q <= ST_HIGH;
                        end else begin
                            ncs_q   <= 1'b1;
                            done_q  <= 1'b1;
                            copi_q  <= 1'b0;
                            phase_q <= c_GAP_RELOAD;
                            state_q <= ST_GAP;
                        end
                    end else begin
                        phase_q <= phase_q - PW'(1);
                    end
                end
                ST_GAP: begin
                    if (phase_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        phase_q <= phase_q - PW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign SCLK       = sclk_q;
    assign COPI       = copi_q;
    assign nCS        = ncs_q;
    assign done       = done_q;
    assign err        = err_q;
    assign fifo_count = count_q;
    assign busy       = (count_q != '0) || (state_q != ST_IDLE);

endmodule
`default_nettype wire
